mips_multicycle_control: RTL and testbench

//  Multi-cycle MIPS control FSM: successor to the single-cycle control decoder. Sequences each

---
 rtl/mips_pkg.sv | 40 ++++
 rtl/mips_multicycle_control_if.sv | 20 ++
 rtl/mips_mem_watchdog.sv | 16 +
 rtl/mips_multicycle_control.sv | 63 ++++++
 tb/tb_mips_multicycle_control.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: opcodes, FSM states, ALU/mux encodings and opcode dispatch for the multicycle control
package mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEX, ALUWB, IMMEX, IMMWB, BRANCH, JUMP
  } state_t;
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_4    = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM2 = 2'b11;
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  // FETCH doubles as the "illegal opcode" answer since that is where an illegal instruction goes
  function automatic state_t dispatch(logic [5:0] op, logic en_bne, logic en_logic);
    case (op)
      OP_RTYPE:       return RTEX;
      OP_LW, OP_SW:   return MEMADR;
      OP_BEQ:         return BRANCH;
      OP_BNE:         return en_bne ? BRANCH : FETCH;
      OP_ADDI:        return IMMEX;
      OP_ANDI, OP_ORI: return en_logic ? IMMEX : FETCH;
      OP_J:           return JUMP;
      default:        return FETCH;
    endcase
  endfunction
endpackage

// File: rtl/mips_multicycle_control_if.sv
// mips_multicycle_control_if: opcode/memory handshake in, datapath control strobes out
interface mips_multicycle_control_if #(parameter int ALUOP_W = 3);
  logic [5:0] opcode;
  logic mem_ready;
  logic mem_req, IorD, MemWrite, IRWrite, PCWrite, Branch, BranchNe;
  logic RegDst, MemtoReg, RegWrite, ZeroExt, ALUSrcA;
  logic [1:0] ALUSrcB, PCSrc;
  logic [ALUOP_W-1:0] ALUOp;
  logic instr_done, illegal_op, bus_err;
  modport master(
    input opcode, mem_ready,
    output mem_req, IorD, MemWrite, IRWrite, PCWrite, Branch, BranchNe, RegDst, MemtoReg,
    RegWrite, ZeroExt, ALUSrcA, ALUSrcB, PCSrc, ALUOp, instr_done, illegal_op, bus_err
  );
  modport slave(
    output opcode, mem_ready,
    input mem_req, IorD, MemWrite, IRWrite, PCWrite, Branch, BranchNe, RegDst, MemtoReg,
    RegWrite, ZeroExt, ALUSrcA, ALUSrcB, PCSrc, ALUOp, instr_done, illegal_op, bus_err
  );
endinterface

// File: rtl/mips_mem_watchdog.sv
// mips_mem_watchdog: counts unanswered memory request cycles and flags a timeout
module mips_mem_watchdog #(parameter int MEM_TIMEOUT = 16) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic busy,
  input  logic ready,
  output logic timeout
);
  localparam int W = MEM_TIMEOUT > 1 ? $clog2(MEM_TIMEOUT + 1) : 1;
  logic [W-1:0] cnt;
  assign timeout = (MEM_TIMEOUT != 0) && busy && !ready && (int'(cnt) == MEM_TIMEOUT - 1);
  // wait counter: restarts with each new access, on completion and after a timeout
  always_ff @(posedge clk)
    cnt <= (reset || start || ready || timeout) ? '0 : busy ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control: multicycle MIPS sequencer with memory handshake and timeout watchdog
module mips_multicycle_control
  import mips_pkg::*;
#(
  parameter int ALUOP_W      = 3,
  parameter int MEM_TIMEOUT  = 16,
  parameter bit EN_BNE       = 1,
  parameter bit EN_LOGIC_IMM = 1
) (
  input logic clk,
  input logic reset,
  mips_multicycle_control_if.master bus
);
  state_t state, next;
  logic [5:0] op;
  logic run, req, timeout;
  assign run = !reset;
  assign req = run && state inside {FETCH, MEMRD, MEMWR};
  mips_mem_watchdog #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wd (
    .clk, .reset, .start(state != next), .busy(req), .ready(bus.mem_ready), .timeout
  );
  // next state: memory states wait for mem_ready and bail out to FETCH on timeout
  always_comb begin
    next = FETCH;
    case (state)
      FETCH:  next = bus.mem_ready ? DECODE : FETCH;
      DECODE: next = dispatch(bus.opcode, EN_BNE, EN_LOGIC_IMM);
      MEMADR: next = op == OP_LW ? MEMRD : MEMWR;
      MEMRD:  next = bus.mem_ready ? MEMWB : timeout ? FETCH : MEMRD;
      MEMWR:  next = (bus.mem_ready || timeout) ? FETCH : MEMWR;
      RTEX:   next = ALUWB;
      IMMEX:  next = IMMWB;
      default: next = FETCH;
    endcase
  end
  // state register; opcode is captured in DECODE so later states see a stable class
  always_ff @(posedge clk) begin
    state <= reset ? FETCH : next;
    if (state == DECODE) op <= bus.opcode;
  end
  assign bus.mem_req    = req;
  assign bus.IorD       = run && state inside {MEMRD, MEMWR};
  assign bus.MemWrite   = run && state == MEMWR && !timeout;
  assign bus.IRWrite    = run && state == FETCH && bus.mem_ready;
  assign bus.PCWrite    = run && ((state == FETCH && bus.mem_ready) || state == JUMP);
  assign bus.Branch     = run && state == BRANCH;
  assign bus.BranchNe   = run && state == BRANCH && op == OP_BNE;
  assign bus.RegDst     = run && state == ALUWB;
  assign bus.MemtoReg   = run && state == MEMWB;
  assign bus.RegWrite   = run && state inside {MEMWB, ALUWB, IMMWB};
  assign bus.ZeroExt    = run && state inside {IMMEX, IMMWB} && op inside {OP_ANDI, OP_ORI};
  assign bus.ALUSrcA    = run && state inside {MEMADR, RTEX, IMMEX, BRANCH};
  assign bus.ALUSrcB    = !run ? SRCB_B : state == FETCH ? SRCB_4 : state == DECODE ? SRCB_IMM2 :
                          state inside {MEMADR, IMMEX} ? SRCB_IMM : SRCB_B;
  assign bus.PCSrc      = !run ? PC_ALU : state == BRANCH ? PC_ALUOUT : state == JUMP ? PC_JUMP : PC_ALU;
  assign bus.ALUOp      = ALUOP_W'(!run ? ALU_ADD : state == RTEX ? ALU_FUNCT : state == BRANCH ? ALU_SUB :
                          (state == IMMEX && op == OP_ANDI) ? ALU_AND :
                          (state == IMMEX && op == OP_ORI) ? ALU_OR : ALU_ADD);
  assign bus.instr_done = run && (state inside {MEMWB, ALUWB, IMMWB, BRANCH, JUMP} ||
                          (state == MEMWR && bus.mem_ready));
  assign bus.illegal_op = run && state == DECODE && dispatch(bus.opcode, EN_BNE, EN_LOGIC_IMM) == FETCH;
  assign bus.bus_err    = timeout;
endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb_mips_multicycle_control: directed and random checks against an instruction-step model
module tb_mips_multicycle_control;
  typedef struct packed {
    logic mem_req, IorD, MemWrite, IRWrite, PCWrite, Branch, BranchNe;
    logic RegDst, MemtoReg, RegWrite, ZeroExt, ALUSrcA;
    logic [1:0] ALUSrcB, PCSrc;
    logic [2:0] ALUOp;
    logic instr_done, illegal_op, bus_err;
  } outs_t;
  typedef struct {
    int pos;
    logic [5:0] op;
    int wc;
  } mst_t;

  logic clk = 0;
  logic reset = 1;
  logic [5:0] opcode = 0;
  logic mem_ready = 1;
  int checks = 0;
  int errors = 0;
  mst_t m1, m2;
  outs_t g1, g2;

  always #5 clk = ~clk;

  mips_multicycle_control_if #(.ALUOP_W(3)) b1();
  mips_multicycle_control_if #(.ALUOP_W(3)) b2();
  assign b1.opcode = opcode;
  assign b1.mem_ready = mem_ready;
  assign b2.opcode = opcode;
  assign b2.mem_ready = mem_ready;

  mips_multicycle_control #(.ALUOP_W(3), .MEM_TIMEOUT(4), .EN_BNE(1), .EN_LOGIC_IMM(1)) dut1 (
    .clk(clk), .reset(reset), .bus(b1));
  mips_multicycle_control #(.ALUOP_W(3), .MEM_TIMEOUT(0), .EN_BNE(0), .EN_LOGIC_IMM(0)) dut2 (
    .clk(clk), .reset(reset), .bus(b2));

  assign g1 = {b1.mem_req, b1.IorD, b1.MemWrite, b1.IRWrite, b1.PCWrite, b1.Branch, b1.BranchNe,
               b1.RegDst, b1.MemtoReg, b1.RegWrite, b1.ZeroExt, b1.ALUSrcA, b1.ALUSrcB, b1.PCSrc,
               b1.ALUOp, b1.instr_done, b1.illegal_op, b1.bus_err};
  assign g2 = {b2.mem_req, b2.IorD, b2.MemWrite, b2.IRWrite, b2.PCWrite, b2.Branch, b2.BranchNe,
               b2.RegDst, b2.MemtoReg, b2.RegWrite, b2.ZeroExt, b2.ALUSrcA, b2.ALUSrcB, b2.PCSrc,
               b2.ALUOp, b2.instr_done, b2.illegal_op, b2.bus_err};

  // Each instruction is a string of steps: F fetch, D decode, A address, M load access,
  // W load writeback, S store access, X R-exec, Y R-writeback, I imm-exec, J imm-writeback,
  // B branch, P jump. Steps F/M/S wait on memory.
  function automatic string seq(logic [5:0] op);
    case (op)
      6'd0:  return "FDXY";
      6'd35: return "FDAMW";
      6'd43: return "FDAS";
      6'd4, 6'd5: return "FDB";
      6'd8, 6'd12, 6'd13: return "FDIJ";
      6'd2:  return "FDP";
      default: return "FD";
    endcase
  endfunction

  function automatic bit legal(logic [5:0] o, bit bne_en, bit li_en);
    return o inside {6'd0, 6'd35, 6'd43, 6'd4, 6'd8, 6'd2} || (bne_en && o == 6'd5) ||
           (li_en && o inside {6'd12, 6'd13});
  endfunction

  function automatic byte step(mst_t m);
    string s;
    if (m.pos < 2) s = "FD";
    else s = seq(m.op);
    return s[m.pos];
  endfunction

  function automatic bit tmo(mst_t m, logic rst, logic rdy, int t);
    byte c = step(m);
    return !rst && (c == "F" || c == "M" || c == "S") && !rdy && t != 0 && m.wc + 1 >= t;
  endfunction

  function automatic outs_t model_out(mst_t m, logic rst, logic [5:0] opc, logic rdy, int t,
                                      bit bne_en, bit li_en);
    outs_t o = '0;
    byte c = step(m);
    bit to = tmo(m, rst, rdy, t);
    bit zx = m.op == 6'd12 || m.op == 6'd13;
    if (rst) return o;
    case (c)
      "F": begin o.mem_req = 1; o.ALUSrcB = 2'd1; o.IRWrite = rdy; o.PCWrite = rdy; end
      "D": begin o.ALUSrcB = 2'd3; o.illegal_op = !legal(opc, bne_en, li_en); end
      "A": begin o.ALUSrcA = 1; o.ALUSrcB = 2'd2; end
      "M": begin o.mem_req = 1; o.IorD = 1; end
      "W": begin o.MemtoReg = 1; o.RegWrite = 1; o.instr_done = 1; end
      "S": begin o.mem_req = 1; o.IorD = 1; o.MemWrite = !to; o.instr_done = rdy; end
      "X": begin o.ALUSrcA = 1; o.ALUOp = 3'd2; end
      "Y": begin o.RegDst = 1; o.RegWrite = 1; o.instr_done = 1; end
      "I": begin
        o.ALUSrcA = 1; o.ALUSrcB = 2'd2; o.ZeroExt = zx;
        o.ALUOp = m.op == 6'd12 ? 3'd3 : m.op == 6'd13 ? 3'd4 : 3'd0;
      end
      "J": begin o.RegWrite = 1; o.instr_done = 1; o.ZeroExt = zx; end
      "B": begin
        o.ALUSrcA = 1; o.ALUOp = 3'd1; o.Branch = 1; o.PCSrc = 2'd1; o.instr_done = 1;
        o.BranchNe = m.op == 6'd5;
      end
      "P": begin o.PCWrite = 1; o.PCSrc = 2'd2; o.instr_done = 1; end
      default: ;
    endcase
    o.bus_err = to;
    return o;
  endfunction

  function automatic mst_t model_next(mst_t m, logic rst, logic [5:0] opc, logic rdy, int t,
                                      bit bne_en, bit li_en);
    mst_t n = m;
    byte c = step(m);
    bit to = tmo(m, rst, rdy, t);
    string s;
    if (rst) begin
      n.pos = 0;
      n.wc = 0;
      return n;
    end
    if (c == "F" || c == "M" || c == "S") begin
      if (rdy) begin n.wc = 0; n.pos++; end
      else if (to) begin n.wc = 0; n.pos = 0; end
      else n.wc++;
    end else if (c == "D") begin
      if (legal(opc, bne_en, li_en)) begin n.op = opc; n.pos = 2; end
      else n.pos = 0;
    end else n.pos++;
    s = seq(n.op);
    if (n.pos >= 2 && n.pos >= s.len()) n.pos = 0;
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // one clock: advance models on the edge, apply new inputs, compare both DUTs mid-cycle
  task automatic cyc(input logic r, input logic [5:0] o, input logic rd);
    outs_t e1, e2;
    @(posedge clk);
    m1 = model_next(m1, reset, opcode, mem_ready, 4, 1'b1, 1'b1);
    m2 = model_next(m2, reset, opcode, mem_ready, 0, 1'b0, 1'b0);
    #1;
    reset = r;
    opcode = o;
    mem_ready = rd;
    @(negedge clk);
    e1 = model_out(m1, reset, opcode, mem_ready, 4, 1'b1, 1'b1);
    e2 = model_out(m2, reset, opcode, mem_ready, 0, 1'b0, 1'b0);
    chk("model_dut1", 32'(g1), 32'(e1));
    chk("model_dut2", 32'(g2), 32'(e2));
  endtask

  initial begin
    logic [5:0] ops [9];
    logic [5:0] o;
    logic rd, r;
    int stall, done_at, early;
    ops = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd5, 6'd8, 6'd12, 6'd13, 6'd2};
    m1 = '{0, 6'd0, 0};
    m2 = '{0, 6'd0, 0};
    repeat (3) begin
      cyc(1, 6'd0, 1);
      chk("reset_quiet", 32'(g1), 0);
    end
    cyc(0, 6'd0, 1);
    chk("r_fetch", {b1.mem_req, b1.IRWrite, b1.PCWrite}, 3'b111);
    cyc(0, 6'd0, 1);
    chk("r_decode_srcb", b1.ALUSrcB, 2'b11);
    cyc(0, 6'd0, 1);
    chk("r_exec_aluop", b1.ALUOp, 3'b010);
    cyc(0, 6'd0, 1);
    chk("r_wb", {b1.RegDst, b1.RegWrite, b1.instr_done}, 3'b111);
    done_at = -1;
    early = 0;
    for (int i = 0; i < 7; i++) begin
      cyc(0, 6'd35, (i == 3 || i == 4) ? 1'b0 : 1'b1);
      if (b1.instr_done && done_at < 0) done_at = i;
      if (b1.RegWrite && i < 6) early = 1;
      if (i == 4) chk("lw_req_held", {b1.mem_req, b1.IorD}, 2'b11);
    end
    chk("lw_cycles", done_at + 1, 7);
    chk("lw_early_regwrite", early, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 6'd4, 1);
      if (i == 2) chk("beq", {b1.Branch, b1.BranchNe, b1.ALUOp, b1.PCSrc}, {2'b10, 3'b001, 2'b01});
    end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 6'd5, 1);
      if (i == 1) chk("bne_disabled_illegal", b2.illegal_op, 1);
      if (i == 2) chk("bne", {b1.Branch, b1.BranchNe, b1.illegal_op}, 3'b110);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(0, 6'd13, 1);
      if (i == 2) chk("ori_exec", {b1.ALUOp, b1.ZeroExt}, {3'b100, 1'b1});
      if (i == 3) chk("ori_wb", {b1.RegWrite, b1.ZeroExt, b1.instr_done}, 3'b111);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(0, 6'd0, 0);
      if (i == 2) chk("timeout_early", b1.bus_err, 0);
      if (i == 3) chk("timeout_buserr", {b1.bus_err, b1.IRWrite, b2.bus_err}, 3'b100);
    end
    cyc(0, 6'd0, 1);
    chk("timeout_refetch", {b1.mem_req, b1.IorD, b1.ALUSrcB, b1.IRWrite}, 5'b10011);
    repeat (3) cyc(0, 6'd0, 1);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 6'd0, i == 3);
      if (i == 3) chk("ready_beats_timeout", {b1.bus_err, b1.IRWrite}, 2'b01);
    end
    repeat (3) cyc(0, 6'd0, 1);
    repeat (3) cyc(0, 6'd43, 1);
    cyc(0, 6'd43, 0);
    chk("sw_stall", {b1.mem_req, b1.MemWrite, b1.instr_done}, 3'b110);
    cyc(1, 6'd43, 1);
    chk("sw_reset", {b1.mem_req, b1.MemWrite, b1.instr_done}, 3'b000);
    cyc(0, 6'd0, 1);
    chk("sw_reset_fetch", {b1.mem_req, b1.IorD, b1.ALUSrcB}, 4'b1001);
    repeat (3) cyc(0, 6'd0, 1);
    stall = 0;
    for (int i = 0; i < 4000; i++) begin
      o = $urandom_range(0, 10) > 8 ? 6'($urandom) : ops[$urandom_range(0, 8)];
      if (stall == 0 && $urandom_range(0, 40) == 0) stall = $urandom_range(2, 7);
      rd = stall > 0 ? 1'b0 : ($urandom_range(0, 9) < 7);
      if (stall > 0) stall--;
      r = $urandom_range(0, 199) == 0;
      cyc(r, o, rd);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
